// File: rtl/fetch_prefetch_buffer_if.sv
// Bundle of the prefetch buffer's signals: the memory read port, the redirect
// input and the fetch-side window and consume handshake.
//   master : the prefetch buffer (drives mem_req/mem_addr and the window)
//   slave  : memory and fetch stage (drive ack/rdata/err, redirect, consume)
interface fetch_prefetch_buffer_if #(
    parameter int ADDR_W    = 64,
    parameter int BUS_BYTES = 8
);
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_ack;
    logic [8*BUS_BYTES-1:0]   mem_rdata;
    logic                     mem_err;
    logic                     instr_valid;
    logic [79:0]              instr;
    logic [ADDR_W-1:0]        instr_pc;
    logic                     consume;
    logic [3:0]               consume_len;
    logic                     imem_error;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, mem_err, consume, consume_len,
        output mem_req, mem_addr, instr_valid, instr, instr_pc, imem_error
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, mem_err, consume, consume_len,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, imem_error
    );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue: streams aligned bus words into a byte-granular
// circular buffer and presents a 10-byte window at the current PC.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : fetch_prefetch_buffer_if.master -- memory req/ack read port,
//              redirect, 80-bit instruction window, consume handshake, error flag
//
// Request FSM:
//   state  | meaning
//   S_IDLE | no request outstanding; may issue when space allows
//   S_REQ  | request outstanding; its data will be written on ack
//   S_DROP | request outstanding across a redirect; its data is discarded
module fetch_prefetch_buffer #(
    parameter int                ADDR_W    = 64,
    parameter int                BUS_BYTES = 8,
    parameter int                BUF_BYTES = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic                     clk_i,
    input logic                     rst_n_i,
    fetch_prefetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFS_W = $clog2(BUS_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BUS_BYTES - 1);
    localparam logic [CNT_W-1:0]  BUF_CNT    = CNT_W'(BUF_BYTES);
    localparam logic [CNT_W-1:0]  BUS_CNT    = CNT_W'(BUS_BYTES);
    localparam logic [CNT_W-1:0]  WIN_CNT    = CNT_W'(10);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;
    state_t state, state_next;

    logic [7:0]        buffer [BUF_BYTES];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr, pc, req_addr;
    logic [OFS_W-1:0]  skip;        // leading bytes of the next word to drop
    logic              err_latched;

    logic              cons_ok, fill_ok, err_ack, issue;
    logic [CNT_W-1:0]  cons_n, wr_n, written, count_post;

    always_comb begin
        cons_ok    = bus.consume && (count >= WIN_CNT) &&
                     (bus.consume_len != 4'd0) && (bus.consume_len <= 4'd10);
        cons_n     = cons_ok ? CNT_W'(bus.consume_len) : '0;
        fill_ok    = (state == S_REQ) && bus.mem_ack && !bus.mem_err && !bus.redirect;
        err_ack    = (state == S_REQ) && bus.mem_ack && bus.mem_err && !bus.redirect;
        wr_n       = BUS_CNT - CNT_W'(skip);
        written    = fill_ok ? wr_n : '0;
        count_post = count - cons_n;
    end

    // A redirect seen while idle issues straight away for the new PC, since
    // the buffer is empty from that edge on.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.redirect ||
                    (!err_latched && (BUF_CNT - count_post >= BUS_CNT))) begin
                    state_next = S_REQ;
                    issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.mem_ack)       state_next = S_IDLE;
                else if (bus.redirect) state_next = S_DROP;
            end
            S_DROP: begin
                if (bus.mem_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_addr  <= RESET_PC & ALIGN_MASK;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC & ALIGN_MASK;
            skip        <= RESET_PC[OFS_W-1:0];
            err_latched <= 1'b0;
        end else begin
            if (issue)
                req_addr <= bus.redirect ? (bus.redirect_pc & ALIGN_MASK) : fetch_addr;
            if (bus.redirect) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                pc          <= bus.redirect_pc;
                fetch_addr  <= bus.redirect_pc & ALIGN_MASK;
                skip        <= bus.redirect_pc[OFS_W-1:0];
                err_latched <= 1'b0;
            end else begin
                if (cons_ok) begin
                    rd_ptr <= rd_ptr + PTR_W'(bus.consume_len);
                    pc     <= pc + ADDR_W'(bus.consume_len);
                end
                if (fill_ok) begin
                    wr_ptr     <= wr_ptr + wr_n[PTR_W-1:0];
                    fetch_addr <= fetch_addr + ADDR_W'(BUS_BYTES);
                    skip       <= '0;
                end
                if (err_ack) err_latched <= 1'b1;
                count <= count_post + written;
            end
        end
    end

    // Byte i of the word lands at wr_ptr + i - skip; bytes below skip are dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BUF_BYTES; i++) buffer[i] <= '0;
        end else if (fill_ok) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                if (OFS_W'(i) >= skip)
                    buffer[wr_ptr + PTR_W'(i) - PTR_W'(skip)] <= bus.mem_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        bus.instr = '0;
        for (int i = 0; i < 10; i++)
            bus.instr[8*i +: 8] = buffer[rd_ptr + PTR_W'(i)];
    end

    assign bus.mem_req     = (state != S_IDLE);
    assign bus.mem_addr    = req_addr;
    assign bus.instr_valid = (count >= WIN_CNT);
    assign bus.instr_pc    = pc;
    assign bus.imem_error  = err_latched && (count < WIN_CNT);
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: a memory responder with configurable wait
// states and fault injection, a fetch-side driver, and a scoreboard monitor
// that checks every accepted consume against the expected PC and memory bytes.
module tb_fetch_prefetch_buffer;
    localparam int ADDR_W    = 64;
    localparam int BUS_BYTES = 8;
    localparam int BUF_BYTES = 32;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fetch_prefetch_buffer_if #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) bus ();

    fetch_prefetch_buffer #(
        .ADDR_W   (ADDR_W),
        .BUS_BYTES(BUS_BYTES),
        .BUF_BYTES(BUF_BYTES),
        .RESET_PC ('0)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] sb_q[$];
    logic [63:0] model_pc;

    int          mem_wait = 0;
    bit          mem_rand = 1'b0;
    bit          err_en   = 1'b0;
    logic [63:0] err_addr = '0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [79:0] exp_window(input logic [63:0] p);
        logic [79:0] w;
        for (int i = 0; i < 10; i++) w[8*i +: 8] = mem_byte(p + 64'(i));
        return w;
    endfunction

    // Memory responder: acks after cur_wait cycles of a held request.
    initial begin
        int cnt      = 0;
        int cur_wait = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_err   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i || !bus.mem_req) begin
                bus.mem_ack = 1'b0;
                bus.mem_err = 1'b0;
                cnt         = 0;
                cur_wait    = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
            end else if (cnt >= cur_wait) begin
                check("mem_addr_align", 80'(bus.mem_addr[2:0]), 80'(0));
                bus.mem_ack = 1'b1;
                for (int i = 0; i < BUS_BYTES; i++)
                    bus.mem_rdata[8*i +: 8] = mem_byte(bus.mem_addr + 64'(i));
                bus.mem_err = err_en && (bus.mem_addr == err_addr);
                cnt         = 0;
            end else begin
                bus.mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Scoreboard monitor: every accepted consume must present the expected window.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && bus.consume && bus.instr_valid &&
                bus.consume_len >= 4'd1 && bus.consume_len <= 4'd10) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: consume at pc 0x%0h with no expected entry", bus.instr_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("instr_pc", 80'(bus.instr_pc), 80'(e));
                    check("instr", bus.instr, exp_window(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.instr_valid && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
    endtask

    task automatic consume_one(input int len);
        wait_valid();
        if (!bus.instr_valid) begin
            n_checks++;
            $display("FAIL consume_timeout: instr_valid stayed 0, expected 1");
        end else begin
            sb_q.push_back(model_pc);
            model_pc        = model_pc + 64'(len);
            bus.consume     = 1'b1;
            bus.consume_len = 4'(len);
            @(posedge clk_i);
            #1;
            bus.consume     = 1'b0;
        end
    endtask

    task automatic do_redirect(input logic [63:0] p);
        bus.redirect    = 1'b1;
        bus.redirect_pc = p;
        model_pc        = p;
        @(posedge clk_i);
        #1;
        bus.redirect    = 1'b0;
    endtask

    initial begin
        int pat [4] = '{10, 1, 9, 2};
        int total;
        int t;
        int reqs;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.consume     = 1'b0;
        bus.consume_len = '0;
        model_pc        = '0;

        // Reset values
        #12;
        check("rst_mem_req", 80'(bus.mem_req), 80'(0));
        check("rst_mem_addr", 80'(bus.mem_addr), 80'(0));
        check("rst_instr_valid", 80'(bus.instr_valid), 80'(0));
        check("rst_instr", bus.instr, 80'(0));
        check("rst_instr_pc", 80'(bus.instr_pc), 80'(0));
        check("rst_imem_error", 80'(bus.imem_error), 80'(0));

        // First fill with zero-wait memory
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("first_req", 80'(bus.mem_req), 80'(1));
        check("first_addr", 80'(bus.mem_addr), 80'(0));
        @(posedge clk_i); #1;
        check("valid_after_ack1", 80'(bus.instr_valid), 80'(0));
        @(posedge clk_i); #1;
        check("valid_before_ack2", 80'(bus.instr_valid), 80'(0));
        @(posedge clk_i); #1;
        check("valid_after_ack2", 80'(bus.instr_valid), 80'(1));
        check("first_window", bus.instr, 80'h09080706050403020100);
        check("first_pc", 80'(bus.instr_pc), 80'(0));

        // Streaming with the 10/1/9/2 pattern across many pointer wraps
        total = 0;
        for (int k = 0; total < 200; k++) begin
            consume_one(pat[k % 4]);
            total += pat[k % 4];
            if ($urandom_range(0, 3) == 0) wait_cycles(1);
        end

        // Out-of-range lengths leave the window alone
        wait_valid();
        bus.consume     = 1'b1;
        bus.consume_len = 4'd0;
        @(posedge clk_i); #1;
        bus.consume_len = 4'd11;
        @(posedge clk_i); #1;
        bus.consume     = 1'b0;
        check("badlen_pc", 80'(bus.instr_pc), 80'(model_pc));
        check("badlen_instr", bus.instr, exp_window(model_pc));
        check("badlen_valid", 80'(bus.instr_valid), 80'(1));

        // Redirect to an unaligned PC while idle
        wait_cycles(20);
        check("idle_before_redirect", 80'(bus.mem_req), 80'(0));
        do_redirect(64'h1005);
        t = 0;
        while (!bus.mem_req && t < 5) begin
            @(posedge clk_i); #1;
            t++;
        end
        check("redirect_addr", 80'(bus.mem_addr), 80'(64'h1000));
        for (int k = 0; k < 12; k++) consume_one(int'($urandom_range(1, 10)));

        // Redirect while a slow request to 0x18 is outstanding
        mem_wait = 3;
        wait_cycles(20);
        do_redirect(64'h0);
        t = 0;
        while (!(bus.mem_req && bus.mem_addr == 64'h18) && t < 200) begin
            @(posedge clk_i); #1;
            t++;
        end
        check("req_0x18_seen", 80'(bus.mem_req && bus.mem_addr == 64'h18), 80'(1));
        do_redirect(64'h40);
        t = 0;
        while (!(bus.mem_req && bus.mem_addr != 64'h18) && t < 50) begin
            @(posedge clk_i); #1;
            t++;
        end
        check("drop_next_addr", 80'(bus.mem_addr), 80'(64'h40));
        for (int k = 0; k < 10; k++) consume_one(int'($urandom_range(1, 10)));
        mem_wait = 0;

        // Access fault on the word at 0x10 with 12 bytes buffered
        err_en   = 1'b1;
        err_addr = 64'h10;
        do_redirect(64'h4);
        wait_cycles(15);
        check("err_valid_12B", 80'(bus.instr_valid), 80'(1));
        check("err_not_yet", 80'(bus.imem_error), 80'(0));
        consume_one(10);
        check("err_valid_after", 80'(bus.instr_valid), 80'(0));
        check("err_flag", 80'(bus.imem_error), 80'(1));
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_req) reqs++;
            @(posedge clk_i); #1;
        end
        check("no_req_after_err", 80'(reqs), 80'(0));
        err_en = 1'b0;
        do_redirect(64'h100);
        check("err_cleared", 80'(bus.imem_error), 80'(0));

        // Random lengths, random wait states, occasional redirects
        mem_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 15) == 0) do_redirect(64'($urandom_range(0, 1023)));
            consume_one(int'($urandom_range(1, 10)));
            if ($urandom_range(0, 7) == 0) wait_cycles(int'($urandom_range(1, 3)));
        end

        wait_cycles(2);
        check("sb_drained", 80'(sb_q.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
